// File: rtl/bus_arb.sv
// bus_arb: round-robin read-bus arbiter. Grants one requester at a time,
// drives the address and read strobe for WAIT_CYCLES+1 cycles, captures the
// bus data and returns it with a one-cycle valid pulse to the winner.
//
// Ports:
//   clk_i       clock, rising edge
//   reset_i     asynchronous active-low reset
//   req_i       per-requester read request (level)
//   ad_i        per-requester address, slice k at [k*AD_LEN +: AD_LEN]
//   bus_data_i  read data from the bus
//   bus_ad_o    bus address (held between transactions)
//   bus_rd_o    bus read strobe
//   gnt_o       one-hot grant, held for the whole transaction
//   data_o      captured read data, broadcast to all requesters
//   valid_o     one-hot, one-cycle data-valid pulse to the winner
//   busy_o      high whenever a transaction is in flight
module bus_arb #(
  parameter int unsigned AD_LEN      = 32,
  parameter int unsigned BUS_WIDTH   = 32,
  parameter int unsigned NREQ        = 2,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*AD_LEN-1:0]   ad_i,
  input  logic [BUS_WIDTH-1:0]     bus_data_i,
  output logic [AD_LEN-1:0]        bus_ad_o,
  output logic                     bus_rd_o,
  output logic [NREQ-1:0]          gnt_o,
  output logic [BUS_WIDTH-1:0]     data_o,
  output logic [NREQ-1:0]          valid_o,
  output logic                     busy_o
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StAddr, StDone} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [AD_LEN-1:0]      ad_q, ad_d;
  logic                   rd_q, rd_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic [NREQ-1:0]        valid_q, valid_d;

  logic                   win_found;
  logic [IdxW-1:0]        win_idx;
  int unsigned            scan_idx;

  // Round-robin pick: first set request scanning last+1, last+2, ... mod NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    scan_idx  = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      scan_idx = (32'(last_q) + i) % NREQ;
      if (!win_found && req_i[scan_idx[IdxW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ad_d    = ad_q;
    rd_d    = rd_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        rd_d    = 1'b0;
        gnt_d   = '0;
        valid_d = '0;
        if (win_found) begin
          ad_d           = ad_i[32'(win_idx)*AD_LEN +: AD_LEN];
          gnt_d[win_idx] = 1'b1;
          rd_d           = 1'b1;
          cnt_d          = 4'd0;
          last_d         = win_idx;
          state_d        = StAddr;
        end
      end
      StAddr: begin
        if (cnt_q == 4'(WAIT_CYCLES)) begin
          data_d  = bus_data_i;
          valid_d = gnt_q;
          rd_d    = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        valid_d = '0;
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= StIdle;
      last_q  <= IdxW'(NREQ - 1);
      cnt_q   <= 4'd0;
      ad_q    <= '0;
      rd_q    <= 1'b0;
      gnt_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ad_q    <= ad_d;
      rd_q    <= rd_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus_ad_o = ad_q;
  assign bus_rd_o = rd_q;
  assign gnt_o    = gnt_q;
  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_bus_arb.sv
module tb_bus_arb;

  localparam int unsigned W = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req;
  logic [63:0] ad;
  logic [31:0] bus_data;

  logic [31:0] a_ad;
  logic        a_rd;
  logic [1:0]  a_gnt;
  logic [31:0] a_data;
  logic [1:0]  a_valid;
  logic        a_busy;

  logic [31:0] b_ad;
  logic        b_rd;
  logic [1:0]  b_gnt;
  logic [31:0] b_data;
  logic [1:0]  b_valid;
  logic        b_busy;

  always #5 clk = ~clk;

  bus_arb #(.AD_LEN(32), .BUS_WIDTH(32), .NREQ(2), .WAIT_CYCLES(W)) dut (
    .clk_i(clk), .reset_i(reset_n), .req_i(req), .ad_i(ad), .bus_data_i(bus_data),
    .bus_ad_o(a_ad), .bus_rd_o(a_rd), .gnt_o(a_gnt), .data_o(a_data),
    .valid_o(a_valid), .busy_o(a_busy)
  );

  bus_arb #(.AD_LEN(32), .BUS_WIDTH(32), .NREQ(2), .WAIT_CYCLES(3)) dut3 (
    .clk_i(clk), .reset_i(reset_n), .req_i(req), .ad_i(ad), .bus_data_i(bus_data),
    .bus_ad_o(b_ad), .bus_rd_o(b_rd), .gnt_o(b_gnt), .data_o(b_data),
    .valid_o(b_valid), .busy_o(b_busy)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: round-robin pointer and held output values.
  int          last_m;
  logic [31:0] exp_ad_m;
  logic [31:0] exp_data_m;
  int          vcnt[2];

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d;
    logic [1:0]  exp_gnt;
    logic [31:0] exp_ad;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner under round-robin: first set bit scanning last+1, last+2, ... mod 2.
  function automatic int rr_pick(input int last, input logic [1:0] r);
    for (int i = 1; i <= 2; i++) begin
      if (r[(last + i) % 2]) return (last + i) % 2;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    last_m = 1;
    exp_ad_m = '0;
    exp_data_m = '0;
  endtask

  // One IDLE cycle with no request: nothing granted, held values unchanged.
  task automatic idle_cycle();
    @(negedge clk);
    req = 2'b00;
    ad = {$urandom, $urandom};
    @(posedge clk);
    #1;
    chk("idle_gnt", a_gnt, 2'b00);
    chk("idle_rd", a_rd, 1'b0);
    chk("idle_valid", a_valid, 2'b00);
    chk("idle_busy", a_busy, 1'b0);
    chk("idle_ad_hold", a_ad, exp_ad_m);
    chk("idle_data_hold", a_data, exp_data_m);
  endtask

  // A full transaction starting from IDLE; ends after the DONE->IDLE edge.
  task automatic run_txn(input logic [1:0] r, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d, input logic [1:0] mid,
                         input logic [1:0] exp_gnt, input logic [31:0] exp_ad);
    @(negedge clk);
    req = r;
    ad = {a1, a0};
    @(posedge clk);
    #1;
    chk("grant_gnt", a_gnt, exp_gnt);
    chk("grant_ad", a_ad, exp_ad);
    chk("grant_rd", a_rd, 1'b1);
    chk("grant_valid", a_valid, 2'b00);
    chk("grant_busy", a_busy, 1'b1);
    for (int j = 0; j <= int'(W); j++) begin
      @(negedge clk);
      bus_data = (j == int'(W)) ? d : $urandom;
      req = mid;
      ad = {$urandom, $urandom};
      @(posedge clk);
      #1;
      chk("addr_gnt", a_gnt, exp_gnt);
      chk("addr_ad", a_ad, exp_ad);
      chk("valid_in_gnt", a_valid & ~a_gnt, 2'b00);
      if (j < int'(W)) begin
        chk("wait_rd", a_rd, 1'b1);
        chk("wait_valid", a_valid, 2'b00);
      end else begin
        chk("done_valid", a_valid, exp_gnt);
        chk("done_data", a_data, d);
        chk("done_rd", a_rd, 1'b0);
        chk("done_busy", a_busy, 1'b1);
        if (a_valid[0]) vcnt[0]++;
        if (a_valid[1]) vcnt[1]++;
      end
    end
    @(negedge clk);
    req = mid;
    @(posedge clk);
    #1;
    chk("end_gnt", a_gnt, 2'b00);
    chk("end_valid", a_valid, 2'b00);
    chk("end_rd", a_rd, 1'b0);
    chk("end_busy", a_busy, 1'b0);
    chk("end_data", a_data, d);
    last_m = exp_gnt[1] ? 1 : 0;
    exp_ad_m = exp_ad;
    exp_data_m = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs[8];
    logic [1:0]  r;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d;
    int          w;
    int          rd_cnt;

    vecs[0] = '{2'b11, 32'h100,       32'h200,       32'h1111_0001, 2'b01, 32'h100};
    vecs[1] = '{2'b11, 32'h100,       32'h200,       32'h1111_0002, 2'b10, 32'h200};
    vecs[2] = '{2'b01, 32'h0000_1000, 32'h0,         32'hDEAD_BEEF, 2'b01, 32'h0000_1000};
    vecs[3] = '{2'b10, 32'h0,         32'h2468,      32'h1111_0003, 2'b10, 32'h2468};
    vecs[4] = '{2'b10, 32'h0,         32'h2470,      32'h1111_0004, 2'b10, 32'h2470};
    vecs[5] = '{2'b11, 32'h300,       32'h400,       32'h1111_0005, 2'b01, 32'h300};
    vecs[6] = '{2'b01, 32'h304,       32'h404,       32'h1111_0006, 2'b01, 32'h304};
    vecs[7] = '{2'b11, 32'h308,       32'h408,       32'h1111_0007, 2'b10, 32'h408};

    reset_n = 1'b0;
    req = 2'b00;
    ad = '0;
    bus_data = '0;
    #1;
    chk("rst_ad", a_ad, 32'h0);
    chk("rst_rd", a_rd, 1'b0);
    chk("rst_gnt", a_gnt, 2'b00);
    chk("rst_valid", a_valid, 2'b00);
    chk("rst_data", a_data, 32'h0);
    chk("rst_busy", a_busy, 1'b0);
    do_reset();
    idle_cycle();

    // Table-driven transactions from reset.
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].d, vecs[i].req,
              vecs[i].exp_gnt, vecs[i].exp_ad);
    end

    // Continuous contention: 8 transactions alternate, 4 pulses each.
    vcnt[0] = 0;
    vcnt[1] = 0;
    for (int t = 0; t < 8; t++) begin
      w = rr_pick(last_m, 2'b11);
      run_txn(2'b11, 32'h5000 + t, 32'h6000 + t, $urandom, 2'b11,
              2'(1 << w), (w == 0) ? 32'h5000 + t : 32'h6000 + t);
    end
    chk("contention_cnt0", vcnt[0], 4);
    chk("contention_cnt1", vcnt[1], 4);

    // Dropped request: transaction completes, no grant afterwards.
    run_txn(2'b10, 32'h0, 32'hABC0, 32'hCAFE_0001, 2'b00, 2'b10, 32'hABC0);
    idle_cycle();

    // Reset during the 2nd ADDR cycle: outputs clear without a clock edge.
    @(negedge clk);
    req = 2'b01;
    ad = {32'h7777, 32'h5555};
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_ad", a_ad, 32'h0);
    chk("midrst_rd", a_rd, 1'b0);
    chk("midrst_gnt", a_gnt, 2'b00);
    chk("midrst_valid", a_valid, 2'b00);
    chk("midrst_data", a_data, 32'h0);
    chk("midrst_busy", a_busy, 1'b0);
    req = 2'b00;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    last_m = 1;
    exp_ad_m = '0;
    exp_data_m = '0;
    idle_cycle();
    // Pointer is back at NREQ-1, so requester 0 wins a tie.
    run_txn(2'b11, 32'h9000, 32'h9100, 32'hBEEF_0001, 2'b11, 2'b01, 32'h9000);
    run_txn(2'b10, 32'h0, 32'h9200, 32'hBEEF_0002, 2'b10, 2'b10, 32'h9200);

    // Randomized traffic against the round-robin model.
    for (int n = 0; n < 150; n++) begin
      r = 2'($urandom_range(0, 3));
      if (r == 2'b00) begin
        idle_cycle();
      end else begin
        a0 = $urandom;
        a1 = $urandom;
        d = $urandom;
        w = rr_pick(last_m, r);
        run_txn(r, a0, a1, d, 2'($urandom), 2'(1 << w), (w == 0) ? a0 : a1);
      end
    end

    // WAIT_CYCLES=3 instance: data sampled on the 4th ADDR cycle.
    do_reset();
    @(negedge clk);
    req = 2'b01;
    ad = {32'h0, 32'h40};
    @(posedge clk);
    #1;
    rd_cnt = 0;
    if (b_rd) rd_cnt++;
    chk("w3_gnt", b_gnt, 2'b01);
    chk("w3_ad", b_ad, 32'h40);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_data = 32'hA000_0000 + k;
      req = 2'b00;
      @(posedge clk);
      #1;
      if (b_rd) rd_cnt++;
      if (k < 3) chk("w3_no_valid", b_valid, 2'b00);
    end
    chk("w3_valid", b_valid, 2'b01);
    chk("w3_data", b_data, 32'hA000_0003);
    chk("w3_gnt_held", b_gnt, 2'b01);
    @(negedge clk);
    @(posedge clk);
    #1;
    if (b_rd) rd_cnt++;
    chk("w3_rd_cycles", rd_cnt, 4);
    chk("w3_end_gnt", b_gnt, 2'b00);
    chk("w3_end_busy", b_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
Name: bus_arb

Overview:
- Shares the processing element's single read bus (address out, data in) between NREQ requesters, e.g. instruction fetch at index 0 and load/store at index 1.
- Uses round-robin arbitration, one transaction at a time.
- Sequences each read: drives the address and read strobe, waits a fixed number of wait states, captures the data, and returns it with a one-cycle valid pulse to the winner.
- Sits between the requesters and the external bus pins.

Parameters:
- AD_LEN, 32, address width.
- BUS_WIDTH, 32, data width.
- NREQ, 2, number of requesters (2..8).
- WAIT_CYCLES, 1, extra bus cycles before data is sampled (0..15).

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- reset_i  input  1  reset; asynchronous, active-low.
- req_i  input  NREQ  per-requester read request, level-held.
- ad_i  input  NREQ*AD_LEN  per-requester address; slice k is [k*AD_LEN +: AD_LEN].
- bus_data_i  input  BUS_WIDTH  read data from the bus.
- bus_ad_o  output  AD_LEN  bus address.
- bus_rd_o  output  1  bus read strobe.
- gnt_o  output  NREQ  one-hot grant, held for the whole transaction.
- data_o  output  BUS_WIDTH  captured read data, broadcast to all requesters.
- valid_o  output  NREQ  one-hot, one-cycle data-valid pulse to the granted requester.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_i low, takes effect immediately, no clock needed):
  - state=IDLE; bus_ad_o=0, bus_rd_o=0, gnt_o=0, valid_o=0, data_o=0, busy_o=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
  - Any in-flight transaction is aborted: no valid pulse, no retry.
- States: IDLE, ADDR, DONE.
- IDLE:
  - req_i is sampled only in this state.
  - If any bit is set, the winner is the first set index scanning last+1, last+2, ... modulo NREQ.
  - On that edge: latch ad_i slice of the winner into bus_ad_o, set gnt_o bit, bus_rd_o=1, wait counter=0, last=winner, go to ADDR.
  - If no request, stay in IDLE; outputs keep their values except bus_rd_o=0, gnt_o=0, valid_o=0.
  - bus_ad_o holds its last address.
- ADDR:
  - bus_rd_o=1; bus_ad_o and gnt_o are stable.
  - The counter increments each cycle.
  - When counter==WAIT_CYCLES: capture bus_data_i into data_o, assert the valid_o bit of the winner, bus_rd_o=0, go to DONE.
  - ADDR therefore lasts WAIT_CYCLES+1 cycles.
- DONE:
  - valid_o is high for exactly this one cycle; gnt_o is still held.
  - Next edge: valid_o=0, gnt_o=0, go to IDLE.
  - data_o holds until the next capture.
- Latency:
  - Request sampled at edge N, valid_o high during cycle N+WAIT_CYCLES+2.
  - Minimum turnaround between grants is WAIT_CYCLES+3 cycles.
- Requester rules:
  - Hold req_i and ad_i stable until valid_o is seen.
  - Deassert req_i on the edge that ends the valid cycle, otherwise the next IDLE issues a new read.
- Changes to req_i or ad_i during ADDR or DONE are ignored. A requester that drops req mid-transaction still receives its valid pulse.
- Fairness: under continuous requests from all requesters, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 transactions.
- A single active requester is re-granted back-to-back, with one IDLE cycle between transactions.
- gnt_o and valid_o are never multi-hot; valid_o is never set without the matching gnt_o bit.
- Width rules: the wait counter is 4 bits; WAIT_CYCLES=0 gives a one-cycle ADDR phase.

Test Plan:
- Single read: WAIT_CYCLES=1, req_i=01, ad_i[0]=0x0000_1000, bus_data_i=0xDEAD_BEEF during ADDR -> bus_ad_o=0x1000 and bus_rd_o=1 for 2 cycles; valid_o=01 and data_o=0xDEADBEEF 3 cycles after the request edge; gnt_o=01 throughout.
- Simultaneous requests from reset: req_i=11, ad_i[0]=0x100, ad_i[1]=0x200 -> requester 0 is served first (bus_ad_o=0x100), then requester 1 (bus_ad_o=0x200), one IDLE cycle between.
- Continuous contention: both requests held for 8 transactions -> gnt_o sequence 01,10,01,10,...; each requester gets exactly 4 valid pulses.
- Wait states: WAIT_CYCLES=3, data changes every cycle -> data_o equals the bus_data_i present on the 4th ADDR cycle; bus_rd_o high for exactly 4 cycles.
- Reset mid-operation: reset_i driven low during the 2nd ADDR cycle -> all outputs 0 immediately, with no clock edge; after release, req_i=10 is granted to requester 1 (pointer back at NREQ-1) with no stale valid pulse.
- Dropped request: req_i[1] deasserted during ADDR -> transaction completes; valid_o=10 still pulses; the next IDLE issues no grant.
